// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// start/done handshake, exact 2*WIDTH-bit signed product.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_op;
  logic               w_sub;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic               w_accept;
  logic               w_last;

  // Subtraction reuses the adder: invert M and feed the carry-in.
  always_comb begin
    w_op     = r_q[0] ^ r_q1;
    w_sub    = r_q[0];
    w_addend = w_op ? (r_m ^ {(WIDTH+1){w_sub}}) : '0;
    w_sum    = r_a + w_addend + (WIDTH+1)'(w_op & w_sub);
    w_accept = ready & start;
    w_last   = (r_state == S_CALC) && (r_count == CW'(1));
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        ready        = 1'b1;
        done         = 1'b1;
        w_state_next = start ? S_CALC : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Shifted product on the last step is {sum, Q[WIDTH-1:1]} taken before the register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a     <= '0;
      r_m     <= {multiplicand[WIDTH-1], multiplicand};
      r_q     <= multiplier;
      r_q1    <= 1'b0;
      r_count <= CW'(WIDTH);
    end else if (r_state == S_CALC) begin
      r_a     <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
      r_q1    <= r_q[0];
      r_count <= r_count - CW'(1);
      if (w_last) r_product <= {w_sum, r_q[WIDTH-1:1]};
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH=8): directed vectors,
// handshake corner sequences and a randomized back-to-back stream.
module tb_booth_seq_multiplier;

  localparam int unsigned W = 8;
  localparam int unsigned NRAND = 2000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     multiplicand = '0;
  logic [W-1:0]     multiplier = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int checks = 0;
  int passes = 0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] m, logic [W-1:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Counts edges after the accept edge until done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output int lat, output int busy_cnt);
    wait_ready();
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  initial begin
    int lat, bc;
    logic [2*W-1:0] expq[$];
    logic [W-1:0] a, b;
    int n_sent, n_done, cyc, last_done;
    bit saw_done;

    vecs[0] = '{8'd3,    8'd5,    16'h000F};
    vecs[1] = '{8'hF9,   8'd6,    16'hFFD6};
    vecs[2] = '{8'd6,    8'hF9,   16'hFFD6};
    vecs[3] = '{8'd0,    8'h80,   16'h0000};
    vecs[4] = '{8'h80,   8'h80,   16'h4000};
    vecs[5] = '{8'd127,  8'h80,   16'hC080};
    vecs[6] = '{8'hFF,   8'hFF,   16'h0001};
    vecs[7] = '{8'd127,  8'd127,  16'h3F01};

    #12;
    check("rst_ready",   32'(ready),   32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].q, lat, bc);
      check($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
      if (i == 0) check("vec0_busy_cycles", 32'(bc), 32'(W));
    end

    // start held high with changing operands during CALC, then back-to-back 2 x 3.
    wait_ready();
    multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    multiplicand = 8'd100; multiplier = 8'hCE;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done(lat, bc);
    check("held_start_product", 32'(product), 32'h000F);
    multiplicand = 8'd2; multiplier = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drops", 32'(done), 32'd0);
    wait_done(lat, bc);
    check("b2b_product", 32'(product), 32'h0006);
    check("b2b_latency", 32'(lat), 32'(W));

    // Reset in the middle of CALC aborts the operation.
    wait_ready();
    multiplicand = 8'hF9; multiplier = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_ready",   32'(ready),   32'd1);
    check("abort_product", 32'(product), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op(8'hF9, 8'd6, lat, bc);
    check("post_reset_product", 32'(product), 32'hFFD6);

    // Random back-to-back stream with start held high and operands scrambled while busy.
    wait_ready();
    n_sent = 0; n_done = 0; cyc = 0; last_done = -1;
    a = W'($urandom); b = W'($urandom);
    multiplicand = a; multiplier = b; start = 1'b1;
    expq.push_back(ref_mul(a, b)); n_sent++;
    while (n_done < int'(NRAND) && cyc < int'(NRAND * (W + 2) + 100)) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (expq.size() == 0) check("rand_unexpected_done", 32'(done), 32'd0);
        else check($sformatf("rand%0d_product", n_done), 32'(product), 32'(expq.pop_front()));
        if (last_done >= 0) check("rand_done_spacing_ge_w", 32'(cyc - last_done >= int'(W)), 32'd1);
        last_done = cyc;
        n_done++;
      end
      if (n_sent < int'(NRAND)) begin
        a = W'($urandom); b = W'($urandom);
        multiplicand = a; multiplier = b; start = 1'b1;
        if (ready) begin
          expq.push_back(ref_mul(a, b));
          n_sent++;
        end
      end else begin
        start = 1'b0;
      end
    end
    check("rand_all_done", 32'(n_done), 32'(NRAND));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
